// File: rtl/avsd_pll_pkg.sv
// Shared state encoding, default parameters and tolerance helper for the PLL lock sequencer.
// PLL_CTRL_MONITOR_EN (optional) keeps frequency monitoring running after lock.
package avsd_pll_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } pll_state_e;

    localparam int DEF_SETTLE_CYCLES = 32;
    localparam int DEF_WIN_CYCLES    = 64;
    localparam int DEF_EXP_EDGES     = 8;
    localparam int DEF_TOL           = 1;
    localparam int DEF_LOCK_WINDOWS  = 4;
    localparam int DEF_MAX_RETRY     = 3;

    localparam int EDGE_CNT_W = 8;

    function automatic logic in_tol(input logic [EDGE_CNT_W-1:0] edges,
                                    input int exp_edges,
                                    input int tol);
        int e;
        e = int'(edges);
        return (e >= exp_edges - tol) && (e <= exp_edges + tol);
    endfunction

endpackage

// File: rtl/avsd_sync_edge.sv
// Two-flop synchronizer with a one-cycle pulse on every change of the async input.
// Generic building block for any asynchronous level arriving in the REF domain.
module avsd_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/avsd_pll_ctrl.sv
// PLL lock sequencer: VCO enable, settle, windowed frequency check, lock and core reset.
// PLL_CTRL_MONITOR_EN adds post-lock monitoring with a sticky lock_lost output.
module avsd_pll_ctrl
    import avsd_pll_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int EXP_EDGES     = DEF_EXP_EDGES,
    parameter int TOL           = DEF_TOL,
    parameter int LOCK_WINDOWS  = DEF_LOCK_WINDOWS,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       pll_req,
    input  logic       pll_div_tog,
    output logic       en_vco,
    output logic       pll_locked,
    output logic       core_rst,
    output logic       pll_fault,
`ifdef PLL_CTRL_MONITOR_EN
    output logic       lock_lost,
`endif
    output logic [2:0] state
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    pll_state_e            state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [WW-1:0]         win_q, win_d;
    logic [EDGE_CNT_W-1:0] edges_q, edges_d;
    logic [EDGE_CNT_W-1:0] edges_tot;
    logic [GW-1:0]         good_q, good_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  en_vco_q, pll_locked_q, core_rst_q, pll_fault_q;
    logic                  pulse, measuring, win_last, win_good;

    avsd_sync_edge u_sync (
        .clk_i  (CLK),
        .rst_i  (reset),
        .d_i    (pll_div_tog),
        .edge_o (pulse)
    );

`ifdef PLL_CTRL_MONITOR_EN
    logic lost_q, lost_d;
    assign measuring = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
`else
    assign measuring = (state_q == ST_MEASURE);
`endif

    // A pulse landing on the last window cycle still counts toward the verdict
    always_comb begin
        edges_tot = edges_q;
        if (pulse && (edges_q != '1)) begin
            edges_tot = edges_q + 1'b1;
        end
    end

    assign win_last = (win_q == WW'(WIN_CYCLES - 1));
    assign win_good = in_tol(edges_tot, EXP_EDGES, TOL);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        edges_d  = edges_q;
        good_d   = good_q;
        retry_d  = retry_q;
`ifdef PLL_CTRL_MONITOR_EN
        lost_d   = lost_q;
`endif
        if (measuring) begin
            win_d   = win_last ? '0 : win_q + 1'b1;
            edges_d = win_last ? '0 : edges_tot;
        end
        unique case (state_q)
            ST_OFF: begin
                if (pll_req) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    win_d    = '0;
                    edges_d  = '0;
                    state_d  = ST_MEASURE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (win_last) begin
                    if (win_good) begin
                        good_d = good_q + 1'b1;
                        if (good_d == GW'(LOCK_WINDOWS)) begin
                            good_d  = '0;
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_d  = '0;
                        retry_d = retry_q + 1'b1;
                        if (retry_d == RW'(MAX_RETRY)) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end
                end
            end
            ST_LOCKED: begin
`ifdef PLL_CTRL_MONITOR_EN
                // Relock after a lost lock does not consume retries
                if (win_last && !win_good) begin
                    lost_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
`endif
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
        if (!pll_req) begin
            state_d  = ST_OFF;
            settle_d = '0;
            win_d    = '0;
            edges_d  = '0;
            good_d   = '0;
            retry_d  = '0;
`ifdef PLL_CTRL_MONITOR_EN
            lost_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_OFF;
            settle_q     <= '0;
            win_q        <= '0;
            edges_q      <= '0;
            good_q       <= '0;
            retry_q      <= '0;
            en_vco_q     <= 1'b0;
            pll_locked_q <= 1'b0;
            core_rst_q   <= 1'b1;
            pll_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            win_q        <= win_d;
            edges_q      <= edges_d;
            good_q       <= good_d;
            retry_q      <= retry_d;
            en_vco_q     <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE)
                            || (state_d == ST_LOCKED);
            pll_locked_q <= (state_d == ST_LOCKED);
            core_rst_q   <= !((state_d == ST_LOCKED) && (state_q == ST_LOCKED));
            pll_fault_q  <= (state_d == ST_FAULT);
        end
    end

`ifdef PLL_CTRL_MONITOR_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            lost_q <= 1'b0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lock_lost = lost_q;
`endif

    assign en_vco     = en_vco_q;
    assign pll_locked = pll_locked_q;
    assign core_rst   = core_rst_q;
    assign pll_fault  = pll_fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_avsd_pll_ctrl.sv
// Scoreboard bench for avsd_pll_ctrl: cycle-tagged expectations checked by a negedge monitor.
// Covers the PLL_CTRL_MONITOR_EN relock scenario when that macro is defined.
module tb_avsd_pll_ctrl;
    import avsd_pll_pkg::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       pll_req = 1'b0;
    logic       pll_div_tog = 1'b0;
    logic       en_vco, pll_locked, core_rst, pll_fault;
    logic [2:0] state;
    logic       ll_a;

`ifdef PLL_CTRL_MONITOR_EN
    logic lock_lost;
    assign ll_a = lock_lost;
`else
    assign ll_a = 1'b0;
`endif

    avsd_pll_ctrl dut (
        .CLK         (CLK),
        .reset       (reset),
        .pll_req     (pll_req),
        .pll_div_tog (pll_div_tog),
        .en_vco      (en_vco),
        .pll_locked  (pll_locked),
        .core_rst    (core_rst),
        .pll_fault   (pll_fault),
`ifdef PLL_CTRL_MONITOR_EN
        .lock_lost   (lock_lost),
`endif
        .state       (state)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected outputs: o = {en_vco, pll_locked, core_rst, pll_fault, lock_lost}
    typedef struct {
        int         c;
        logic [2:0] st;
        logic [4:0] o;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input int c, input logic [2:0] st, input logic [4:0] o,
                       input string nm);
        exp_t e;
        e.c = c; e.st = st; e.o = o; e.nm = nm;
        sbq.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        logic [4:0] act;
        act = {en_vco, pll_locked, core_rst, pll_fault, ll_a};
        while (sbq.size() > 0 && sbq[0].c <= cyc) begin
            e = sbq.pop_front();
            n_cmp++;
            if (e.c < cyc) begin
                n_bad++;
                $display("FAIL %s: check slot %0d missed (now %0d)", e.nm, e.c, cyc);
            end else if (state !== e.st || act !== e.o) begin
                n_bad++;
                $display("FAIL %s @%0d: got st=%0d out=%b, want st=%0d out=%b",
                         e.nm, cyc, state, act, e.st, e.o);
            end
        end
    end

    // Toggle generator: mode 1 periodic, mode 2 per-window edge counts
    int tog_mode = 0;
    int tog_per  = 8;
    int tog_base = 0;
    int meas_s   = 0;
    int wcnt[4];

    always @(posedge CLK) begin
        #2;
        if (tog_mode == 1) begin
            if (((cyc - tog_base) % tog_per) == 0) pll_div_tog = ~pll_div_tog;
        end else if (tog_mode == 2) begin
            for (int w = 0; w < 4; w++) begin
                for (int i = 0; i < wcnt[w]; i++) begin
                    if (cyc == meas_s + 64 * w + 4 + 6 * i) pll_div_tog = ~pll_div_tog;
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d checks pending", sbq.size());
        n_bad++;
        summary();
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        exp_t e;
        // Reset held with request high, ideal toggle every 8 cycles
        pll_req  = 1'b1;
        tog_mode = 1; tog_per = 8; tog_base = 0;
        wait_until(2);
        chk(2, ST_OFF, 5'b00100, "reset_state");
        wait_until(3);
        reset = 1'b0;
        t = cyc;
        chk(t,       ST_OFF,     5'b00100, "off_after_release");
        chk(t + 1,   ST_SETTLE,  5'b10100, "en_vco_1cyc");
        chk(t + 33,  ST_MEASURE, 5'b10100, "measure_entry");
        chk(t + 288, ST_MEASURE, 5'b10100, "not_locked_288");
        chk(t + 289, ST_LOCKED,  5'b11100, "locked_289");
        chk(t + 290, ST_LOCKED,  5'b11000, "core_rst_290");
        wait_until(t + 300);
        chk(t + 300, ST_LOCKED,  5'b11000, "locked_hold");
        pll_req = 1'b0;
        chk(t + 301, ST_OFF,     5'b00100, "drop_in_locked");

        // Drop mid-measure, then full relock proves counters cleared
        wait_until(t + 303);
        pll_req = 1'b1;
        t = cyc;
        wait_until(t + 150);
        chk(t + 150, ST_MEASURE, 5'b10100, "mid_measure");
        pll_req = 1'b0;
        chk(t + 151, ST_OFF,     5'b00100, "drop_in_measure");
        wait_until(t + 152);
        pll_req = 1'b1;
        t = cyc;
        chk(t + 288, ST_MEASURE, 5'b10100, "relock_not_early");
        chk(t + 289, ST_LOCKED,  5'b11100, "relock_289");
        chk(t + 294, ST_LOCKED,  5'b11000, "locked_pre_reset");
        wait_until(t + 295);
        #2;
        reset = 1'b1;
        chk(t + 295, ST_OFF,     5'b00100, "async_reset");
        pll_req = 1'b0;
        wait_until(t + 297);
        reset = 1'b0;

        // Double-rate toggle: three bad windows, then FAULT
        wait_until(t + 300);
        tog_per = 4; tog_base = cyc;
        pll_req = 1'b1;
        t = cyc;
        chk(t + 97,  ST_SETTLE,  5'b10100, "bad_window_retry");
        chk(t + 288, ST_MEASURE, 5'b10100, "third_attempt");
        chk(t + 289, ST_FAULT,   5'b00110, "fault");
        wait_until(t + 300);
        chk(t + 300, ST_FAULT,   5'b00110, "fault_hold");
        pll_req = 1'b0;
        chk(t + 301, ST_OFF,     5'b00100, "fault_exit");

        // Windows with 7/8/9 edges pass, 10 fails
        wait_until(t + 303);
        tog_mode = 2;
        wcnt = '{7, 8, 9, 10};
        pll_req = 1'b1;
        t = cyc;
        meas_s = t + 33;
        chk(t + 288, ST_MEASURE, 5'b10100, "win_7_8_9_good");
        chk(t + 289, ST_SETTLE,  5'b10100, "win_10_bad");
        wait_until(t + 289);
        tog_mode = 1; tog_per = 8; tog_base = cyc;
        chk(t + 385, ST_MEASURE, 5'b10100, "good_count_cleared");
        chk(t + 577, ST_LOCKED,  5'b11100, "lock_after_retry");
        wait_until(t + 580);
        pll_req = 1'b0;
        chk(t + 581, ST_OFF,     5'b00100, "drop_after_retry");

`ifdef PLL_CTRL_MONITOR_EN
        // Stop toggling while locked: lock_lost and resettle, then relock
        wait_until(t + 583);
        pll_req = 1'b1;
        t = cyc;
        chk(t + 289, ST_LOCKED,  5'b11100, "mon_lock");
        wait_until(t + 300);
        tog_mode = 0;
        chk(t + 352, ST_LOCKED,  5'b11000, "mon_still_locked");
        chk(t + 353, ST_SETTLE,  5'b10101, "mon_lock_lost");
        wait_until(t + 360);
        tog_mode = 1; tog_per = 8; tog_base = cyc;
        chk(t + 641, ST_LOCKED,  5'b11101, "mon_relock_sticky");
        wait_until(t + 645);
        pll_req = 1'b0;
        chk(t + 646, ST_OFF,     5'b00100, "mon_lost_cleared");
        t = t + 646;
`else
        t = t + 581;
`endif
        wait_until(t + 5);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check slot %0d never reached", e.nm, e.c);
        end
        summary();
        $finish;
    end

endmodule
